// File: rtl/intr_pkg.sv
// Shared constants and types for the interrupt controller.
// Optional feature macro used by intr_ctrl: INTR_CTRL_NEST_EN (nested interrupts).
package intr_pkg;

  // Register map
  localparam logic [1:0] ADDR_CTRL = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_PEND = 2'd2;
  localparam logic [1:0] ADDR_MODE = 2'd3;

  // CTRL bit positions; stack level occupies bits [CNT_W-1:0]
  localparam int unsigned CTRL_GIE_BIT = 15;
  localparam int unsigned CTRL_ERR_BIT = 14;

  // Level encoding holds 0..16, where NUM_CH means "none in service"
  localparam int unsigned LVL_W     = 5;
  // Stack occupancy 0..8 and storage index 0..7
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned IDX_W     = 3;
  localparam int unsigned MAX_DEPTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TAKE = 2'd1,
    ST_RET  = 2'd2
  } state_e;

endpackage

// File: rtl/intr_stack.sv
// LIFO of {saved PC, in-service level} entries with push/pop and full/empty flags.
module intr_stack
  import intr_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PC_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [PC_W-1:0]  push_pc,
  input  logic [LVL_W-1:0] push_lvl,
  output logic [PC_W-1:0]  top_pc_c,
  output logic [LVL_W-1:0] top_lvl_c,
  output logic             full_c,
  output logic             empty_c,
  output logic [CNT_W-1:0] count
);

  logic [PC_W-1:0]  mem_pc  [MAX_DEPTH];
  logic [LVL_W-1:0] mem_lvl [MAX_DEPTH];
  logic [CNT_W-1:0] cnt_q;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] top_idx;

  assign wr_idx    = IDX_W'(cnt_q);
  assign top_idx   = IDX_W'(cnt_q - CNT_W'(1));
  assign full_c    = (cnt_q == CNT_W'(DEPTH));
  assign empty_c   = (cnt_q == '0);
  assign top_pc_c  = mem_pc[top_idx];
  assign top_lvl_c = mem_lvl[top_idx];
  assign count     = cnt_q;

  // Entry storage and occupancy; push is refused when full, pop when empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      for (int i = 0; i < int'(MAX_DEPTH); i++) begin
        mem_pc[i]  <= '0;
        mem_lvl[i] <= '0;
      end
    end else if (push && !full_c) begin
      mem_pc[wr_idx]  <= push_pc;
      mem_lvl[wr_idx] <= push_lvl;
      cnt_q           <= cnt_q + CNT_W'(1);
    end else if (pop && !empty_c) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/intr_ctrl.sv
// Prioritised interrupt controller with saved-PC stack and return handling.
// Macro INTR_CTRL_NEST_EN: defined enables nesting up to STK_DEPTH; undefined
// limits the stack to a single entry (no take while one is in service).
module intr_ctrl
  import intr_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned PC_W       = 8,
  parameter int unsigned STK_DEPTH  = 4,
  parameter logic [7:0]  VEC_BASE   = 8'd19,
  parameter logic [7:0]  VEC_STRIDE = 8'd15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] irq_in,
  input  logic              chk_valid,
  input  logic [PC_W-1:0]   cur_pc,
  input  logic              reti,
  input  logic              reg_we,
  input  logic [1:0]        reg_addr,
  input  logic [15:0]       reg_wdata,
  output logic [15:0]       reg_rdata,
  output logic              int_take,
  output logic [PC_W-1:0]   int_vec,
  output logic              ret_valid,
  output logic [PC_W-1:0]   ret_pc,
  output logic              stk_err
);

`ifdef INTR_CTRL_NEST_EN
  localparam int unsigned EFF_DEPTH = STK_DEPTH;
`else
  // Single-level operation: one entry regardless of STK_DEPTH
  localparam int unsigned EFF_DEPTH = (STK_DEPTH < 1) ? STK_DEPTH : 1;
`endif

  state_e state_q, state_d;

  logic              gie;
  logic [NUM_CH-1:0] mask, pend, mode, irq_prev;
  logic [NUM_CH-1:0] elig, win_oh, pend_set, pend_clr, take_clr;
  logic              win_found;
  logic [LVL_W-1:0]  win_idx, cur_lvl;
  logic              take_ok, push, pop, ret_go, err_set, err_clr;
  logic              ctrl_we, mask_we, pend_we, mode_we;
  logic [PC_W-1:0]   vec_c;
  logic [PC_W-1:0]   top_pc;
  logic [LVL_W-1:0]  top_lvl;
  logic              stk_full, stk_empty;
  logic [CNT_W-1:0]  stk_cnt;
  logic              unused_wdata;

  assign unused_wdata = ^reg_wdata;

  assign ctrl_we = reg_we && (reg_addr == ADDR_CTRL);
  assign mask_we = reg_we && (reg_addr == ADDR_MASK);
  assign pend_we = reg_we && (reg_addr == ADDR_PEND);
  assign mode_we = reg_we && (reg_addr == ADDR_MODE);

  // Edge channels latch a rising edge; level channels latch while high
  assign pend_set = (mode & irq_in & ~irq_prev) | (~mode & irq_in);
  assign pend_clr = pend_we ? reg_wdata[NUM_CH-1:0] : '0;
  assign take_clr = push ? (win_oh & mode) : '0;
  assign err_clr  = ctrl_we && reg_wdata[CTRL_ERR_BIT];

  assign elig    = gie ? (pend & mask) : '0;
  assign cur_lvl = stk_empty ? LVL_W'(NUM_CH) : top_lvl;
  assign take_ok = win_found && (win_idx < cur_lvl) && !stk_full;
  assign vec_c   = PC_W'(32'(VEC_BASE) + 32'(win_idx) * 32'(VEC_STRIDE));

  // Lowest-index eligible channel wins
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_oh    = '0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (elig[i]) begin
        win_found = 1'b1;
        win_idx   = LVL_W'(i);
        win_oh    = '0;
        win_oh[i] = 1'b1;
      end
    end
  end

  // Next-state and stack control; reti takes precedence over chk_valid
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    pop     = 1'b0;
    ret_go  = 1'b0;
    err_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (reti) begin
          state_d = ST_RET;
          ret_go  = 1'b1;
          if (stk_empty) err_set = 1'b1;
          else           pop     = 1'b1;
        end else if (chk_valid && take_ok) begin
          state_d = ST_TAKE;
          push    = 1'b1;
        end
      end
      ST_TAKE: state_d = ST_IDLE;
      ST_RET:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Registered transfer pulses and their address payloads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_take  <= 1'b0;
      int_vec   <= '0;
      ret_valid <= 1'b0;
      ret_pc    <= '0;
    end else begin
      int_take  <= push;
      ret_valid <= ret_go;
      if (push)   int_vec <= vec_c;
      if (ret_go) ret_pc  <= stk_empty ? '0 : top_pc;
    end
  end

  // Software-visible registers, pending latch and edge history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gie      <= 1'b0;
      mask     <= '0;
      mode     <= '0;
      pend     <= '0;
      irq_prev <= '0;
      stk_err  <= 1'b0;
    end else begin
      if (ctrl_we) gie  <= reg_wdata[CTRL_GIE_BIT];
      if (mask_we) mask <= reg_wdata[NUM_CH-1:0];
      if (mode_we) mode <= reg_wdata[NUM_CH-1:0];
      pend     <= (pend & ~pend_clr & ~take_clr) | pend_set;
      irq_prev <= irq_in;
      stk_err  <= (stk_err & ~err_clr) | err_set;
    end
  end

  // Register read mux
  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      ADDR_CTRL: begin
        reg_rdata[CTRL_GIE_BIT] = gie;
        reg_rdata[CTRL_ERR_BIT] = stk_err;
        reg_rdata[CNT_W-1:0]    = stk_cnt;
      end
      ADDR_MASK: reg_rdata = 16'(mask);
      ADDR_PEND: reg_rdata = 16'(pend);
      ADDR_MODE: reg_rdata = 16'(mode);
      default:   reg_rdata = '0;
    endcase
  end

  intr_stack #(
    .DEPTH (EFF_DEPTH),
    .PC_W  (PC_W)
  ) u_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .push_pc   (cur_pc),
    .push_lvl  (win_idx),
    .top_pc_c  (top_pc),
    .top_lvl_c (top_lvl),
    .full_c    (stk_full),
    .empty_c   (stk_empty),
    .count     (stk_cnt)
  );

endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl: directed scenarios plus random traffic
// compared against a queue-based behavioural model.
module tb_intr_ctrl;

`ifdef INTR_CTRL_NEST_EN
  localparam int unsigned DEPTH = 2;
  localparam int          CAP   = 2;
`else
  localparam int unsigned DEPTH = 4;
  localparam int          CAP   = 1;
`endif
  localparam int VB = 19;
  localparam int VS = 15;

  logic        clk;
  logic        rst_n;
  logic [3:0]  irq_in;
  logic        chk_valid;
  logic [7:0]  cur_pc;
  logic        reti;
  logic        reg_we;
  logic [1:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic [15:0] reg_rdata;
  logic        int_take;
  logic [7:0]  int_vec;
  logic        ret_valid;
  logic [7:0]  ret_pc;
  logic        stk_err;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit       m_gie, m_err, m_take, m_ret;
  bit [3:0] m_mask, m_pend, m_mode, m_prev;
  bit [7:0] m_vec, m_rpc;
  int       stk_pc[$];
  int       stk_lvl[$];

  intr_ctrl #(
    .NUM_CH     (4),
    .PC_W       (8),
    .STK_DEPTH  (DEPTH),
    .VEC_BASE   (8'd19),
    .VEC_STRIDE (8'd15)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .irq_in    (irq_in),
    .chk_valid (chk_valid),
    .cur_pc    (cur_pc),
    .reti      (reti),
    .reg_we    (reg_we),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .int_take  (int_take),
    .int_vec   (int_vec),
    .ret_valid (ret_valid),
    .ret_pc    (ret_pc),
    .stk_err   (stk_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_read(input logic [1:0] a);
    logic [15:0] r;
    r = '0;
    case (a)
      2'd0: begin r[15] = m_gie; r[14] = m_err; r[3:0] = 4'(stk_pc.size()); end
      2'd1: r[3:0] = m_mask;
      2'd2: r[3:0] = m_pend;
      default: r[3:0] = m_mode;
    endcase
    return r;
  endfunction

  task automatic model_reset();
    m_gie = 0; m_err = 0; m_take = 0; m_ret = 0;
    m_mask = 0; m_pend = 0; m_mode = 0; m_prev = 0;
    m_vec = 0; m_rpc = 0;
    stk_pc.delete();
    stk_lvl.delete();
  endtask

  // One clock of the reference behaviour, using the inputs seen at the edge
  task automatic model_step();
    bit [3:0] setv, clr;
    int lvl, win;
    bit busy, nt, nr, eset;
    busy = m_take || m_ret;
    setv = (m_mode & irq_in & ~m_prev) | (~m_mode & irq_in);
    clr  = (reg_we && reg_addr == 2'd2) ? reg_wdata[3:0] : 4'd0;
    lvl  = (stk_lvl.size() > 0) ? stk_lvl[$] : 4;
    win  = -1;
    if (m_gie)
      for (int k = 3; k >= 0; k--)
        if (m_pend[k] && m_mask[k]) win = k;
    nt = 0; nr = 0; eset = 0;
    if (!busy && reti) begin
      nr = 1;
      if (stk_pc.size() > 0) begin
        m_rpc = 8'(stk_pc.pop_back());
        void'(stk_lvl.pop_back());
      end else begin
        m_rpc = 0;
        eset  = 1;
      end
    end else if (!busy && chk_valid && win >= 0 && win < lvl && stk_pc.size() < CAP) begin
      nt = 1;
      stk_pc.push_back(int'(cur_pc));
      stk_lvl.push_back(win);
      m_vec = 8'(VB + VS * win);
      if (m_mode[win]) clr[win] = 1'b1;
    end
    m_pend = (m_pend & ~clr) | setv;
    if (reg_we && reg_addr == 2'd0) begin
      m_gie = reg_wdata[15];
      if (reg_wdata[14]) m_err = 0;
    end
    if (eset) m_err = 1;
    if (reg_we && reg_addr == 2'd1) m_mask = reg_wdata[3:0];
    if (reg_we && reg_addr == 2'd3) m_mode = reg_wdata[3:0];
    m_prev = irq_in;
    m_take = nt;
    m_ret  = nr;
  endtask

  task automatic check_outputs();
    chk("int_take", 32'(int_take), 32'(m_take));
    chk("ret_valid", 32'(ret_valid), 32'(m_ret));
    chk("stk_err", 32'(stk_err), 32'(m_err));
    chk("int_vec", 32'(int_vec), 32'(m_vec));
    chk("ret_pc", 32'(ret_pc), 32'(m_rpc));
    chk("reg_rdata", 32'(reg_rdata), 32'(model_read(reg_addr)));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
    chk_valid = 1'b0;
    reti      = 1'b0;
    reg_we    = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    reg_we = 1'b1; reg_addr = a; reg_wdata = d;
    step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    irq_in = '0; chk_valid = 0; reti = 0; reg_we = 0; cur_pc = '0;
    model_reset();
    #1;
    chk("rst_int_take", 32'(int_take), 32'd0);
    chk("rst_int_vec", 32'(int_vec), 32'd0);
    check_outputs();
    for (int a = 0; a < 4; a++) begin
      reg_addr = 2'(a);
      #1;
      chk("rst_reg", 32'(reg_rdata), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    irq_in = '0; chk_valid = 0; cur_pc = '0; reti = 0;
    reg_we = 0; reg_addr = '0; reg_wdata = '0; rst_n = 0;
    do_reset();

    // Level channel 2 taken one cycle after chk_valid
    wr(2'd0, 16'h8000);
    wr(2'd1, 16'h000F);
    irq_in = 4'b0100;
    step();
    chk_valid = 1; cur_pc = 8'h05;
    step();
    chk("take_ch2", 32'(int_take), 32'd1);
    chk("vec_ch2", 32'(int_vec), 32'd49);
    step();

`ifdef INTR_CTRL_NEST_EN
    // Edge channel 0 preempts channel 2, then unwinds in LIFO order
    wr(2'd3, 16'h0001);
    irq_in = 4'b0101;
    step();
    chk_valid = 1; cur_pc = 8'h32;
    step();
    chk("nest_take", 32'(int_take), 32'd1);
    chk("nest_vec", 32'(int_vec), 32'd19);
    step();
    reti = 1;
    step();
    chk("nest_ret1", 32'(ret_pc), 32'h32);
    step();
    reti = 1;
    step();
    chk("nest_ret2_v", 32'(ret_valid), 32'd1);
    chk("nest_ret2", 32'(ret_pc), 32'h05);
    step();
`else
    // Single-entry stack full: higher priority waits until reti
    irq_in = 4'b0011;
    step();
    chk_valid = 1; cur_pc = 8'h40;
    step();
    chk("full_notake", 32'(int_take), 32'd0);
    reti = 1;
    step();
    chk("full_ret_v", 32'(ret_valid), 32'd1);
    chk("full_ret", 32'(ret_pc), 32'h05);
    step();
    chk_valid = 1; cur_pc = 8'h41;
    step();
    chk("retake", 32'(int_take), 32'd1);
    chk("retake_vec", 32'(int_vec), 32'd19);
    step();
    reti = 1;
    step();
    chk("retake_ret", 32'(ret_pc), 32'h41);
    step();
`endif

    // Simultaneous channels 1 and 2: channel 1 wins
    irq_in = 4'b0110;
    wr(2'd2, 16'h000F);
    chk_valid = 1; cur_pc = 8'h20;
    step();
    chk("prio_vec", 32'(int_vec), 32'd34);
    step();
    reti = 1;
    step();
    step();
    irq_in = '0;
    wr(2'd2, 16'h000F);

    // Underflow sets sticky error; write-1 clears it
    reti = 1;
    step();
    chk("uflow_v", 32'(ret_valid), 32'd1);
    chk("uflow_pc", 32'(ret_pc), 32'd0);
    chk("uflow_err", 32'(stk_err), 32'd1);
    step();
    wr(2'd0, 16'hC000);
    chk("err_clr", 32'(stk_err), 32'd0);

    // reti wins over same-cycle chk_valid
    irq_in = 4'b0100;
    step();
    chk_valid = 1; reti = 1; cur_pc = 8'h77;
    step();
    chk("both_take", 32'(int_take), 32'd0);
    chk("both_ret", 32'(ret_valid), 32'd1);
    step();
    wr(2'd0, 16'hC000);

    // Random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      irq_in    = 4'($urandom);
      chk_valid = ($urandom_range(0, 9) < 3);
      reti      = ($urandom_range(0, 9) < 2);
      cur_pc    = 8'($urandom);
      reg_addr  = 2'($urandom);
      reg_we    = ($urandom_range(0, 19) == 0);
      reg_wdata = 16'($urandom);
      if (reg_we && reg_addr == 2'd0) reg_wdata[15] = ($urandom_range(0, 3) != 0);
      step();
    end

    // Reset asserted mid-TAKE aborts the pulse
    do_reset();
    wr(2'd0, 16'h8000);
    wr(2'd1, 16'h000F);
    irq_in = 4'b0001;
    step();
    chk_valid = 1; cur_pc = 8'h11;
    step();
    chk("pre_rst_take", 32'(int_take), 32'd1);
    do_reset();
    step();
    chk("post_rst_take", 32'(int_take), 32'd0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/intr_ctrl.md
INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: interrupt channel count, legal range 1..16.
REQ-002 SHALL have parameter PC_W, default 8: program-counter width.
REQ-003 SHALL have parameter STK_DEPTH, default 4: saved-PC stack depth, legal range 1..8.
REQ-004 SHALL have parameters VEC_BASE (default 8'd19) and VEC_STRIDE (default 8'd15): vector of channel k = VEC_BASE + k*VEC_STRIDE, truncated to PC_W.
REQ-005 clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 rst_n  in  1  reset; asynchronous, active-low.
REQ-007 irq_in  in  NUM_CH  raw interrupt sources, synchronous to clk.
REQ-008 chk_valid  in  1  core at instruction boundary, one-cycle pulse.
REQ-009 cur_pc  in  PC_W  PC to resume; sampled with chk_valid.
REQ-010 reti  in  1  return-from-interrupt, one-cycle pulse.
REQ-011 reg_we  in  1  register write strobe.
REQ-012 reg_addr  in  2  0=CTRL, 1=MASK, 2=PEND, 3=MODE.
REQ-013 reg_wdata  in  16  write data.
REQ-014 reg_rdata  out  16  combinational read of reg_addr.
REQ-015 int_take  out  1  registered pulse: core SHALL load int_vec into PC.
REQ-016 int_vec  out  PC_W  vector address; valid with int_take.
REQ-017 ret_valid  out  1  registered pulse: core SHALL load ret_pc into PC.
REQ-018 ret_pc  out  PC_W  popped PC; valid with ret_valid.
REQ-019 stk_err  out  1  sticky: underflow on reti with empty stack.

Function
REQ-020 CTRL: bit15 GIE (rw), bit14 stk_err (write 1 clears), bits[3:0] stack level (ro).
REQ-021 MODE bit k=1: channel k edge-triggered (rising edge vs. previous-cycle sample); 0: level.
REQ-022 PEND bit k set on edge (edge mode) or while irq_in[k]=1 (level mode); reg write-1 clears; set wins over same-cycle clear.
REQ-023 Eligible set = PEND & MASK when GIE=1; winner = lowest-index eligible channel.
REQ-024 FSM states: IDLE, TAKE, RET; IDLE->TAKE on chk_valid with eligible winner whose index is below current in-service level and stack not full; IDLE->RET on reti; TAKE/RET->IDLE unconditionally after one cycle.
REQ-025 On IDLE->TAKE: push cur_pc, push winner index as in-service level, clear PEND of winner if edge mode; int_take=1 and int_vec valid in TAKE (latency one cycle after chk_valid).
REQ-026 On IDLE->RET with non-empty stack: pop; ret_valid=1 with ret_pc in RET; in-service level reverts to new top (none if empty).
REQ-027 reti with empty stack: no pop, ret_valid=1 with ret_pc=0, stk_err set.
REQ-028 chk_valid and reti in same cycle: reti served, chk_valid ignored.
REQ-029 chk_valid or reti while in TAKE/RET: ignored.
REQ-030 Stack full: no take; PEND retained until space exists.
REQ-031 "None in service" ranks below channel NUM_CH-1; an equal or lower priority channel never preempts.

Reset
REQ-032 rst_n low: state IDLE, CTRL/MASK/PEND/MODE=0, stack empty, stk_err=0, int_take=0, int_vec=0, ret_valid=0, ret_pc=0, edge history=0.
REQ-033 Reset mid-TAKE or mid-RET aborts the transfer; no pulse emitted afterwards.

Configuration
REQ-034 INTR_CTRL_NEST_EN defined: nesting per REQ-024/031.
REQ-035 INTR_CTRL_NEST_EN undefined: effective depth 1; no take while stack non-empty; STK_DEPTH ignored.

Structure
REQ-036 Shared package intr_pkg SHALL hold register address constants, CTRL bit positions, FSM state enum.
REQ-037 Sub-module intr_stack (parametrised LIFO of {PC, level}, push/pop/full/empty) SHALL be used.

Verification
REQ-038 GIE=1, MASK=4'hF, level irq_in=4'b0100, chk_valid cur_pc=8'h05 -> next cycle int_take, int_vec=8'd49.
REQ-039 irq_in=4'b0110 simultaneous -> int_vec=8'd34 (channel 1 wins).
REQ-040 NEST_EN: in ch2 service, edge irq ch0, chk_valid cur_pc=8'h32 -> take 8'd19; reti -> ret_pc=8'h32; reti -> ret_pc=8'h05.
REQ-041 STK_DEPTH=1 full, higher-priority pending -> no int_take; after reti, next chk_valid takes.
REQ-042 reti with empty stack -> ret_valid, ret_pc=0, stk_err=1; write CTRL bit14=1 -> stk_err=0.
REQ-043 rst_n low during TAKE -> int_take=0 immediately, all registers 0.
